tft_bus_arbiter: RTL
====================

// Module: tft_bus_arbiter
// PURPOSE
// Shares the single tft_spi byte transmitter among NUM_CLIENTS drawing engines (tft_init,
// scene_exhibitor, player, ...). Replaces the top-level priority mux of enable flags.
// A client requests the bus for a whole burst; the arbiter grants one client at a time
// (round-robin) and forwards its data/dc/transmit to tft_spi. It releases the bus only
// after the SPI shifter has drained, so TFT command sequences are never interleaved.
// PARAMETERS
// NUM_CLIENTS  4  number of requesters, >= 2; OWNER_W = $clog2(NUM_CLIENTS)
// MAX_HOLD     0  max cycles one grant may last (0 = unlimited); 20-bit hold counter
// PORTS
// clk              in   1          system clock
// rst              in   1          synchronous reset, active-high
// req              in   N          per-client bus request, held high for the whole burst
// client_data      in   8*N        client i byte on [8i+7:8i]
// client_dc        in   N          client i data/command select
// client_transmit  in   N          client i one-cycle byte strobe
// client_busy      out  N          per-client busy: spi_busy if granted, else 1
// grant            out  N          one-hot grant, registered
// owner            out  OWNER_W    index of granted client (valid when active=1)
// active           out  1          a grant is in force
// spi_busy         in   1          busy from tft_spi
// spi_data         out  8          byte to tft_spi
// spi_dc           out  1          dc to tft_spi
// spi_transmit     out  1          transmit strobe to tft_spi
// dropped          out  1          1-cycle pulse: transmit strobe from a non-granted client
// timeout          out  1          1-cycle pulse: grant revoked by MAX_HOLD
// BEHAVIOUR
// - Reset: state=IDLE, grant=0, owner=0, active=0, last=NUM_CLIENTS-1, hold counter=0,
//   dropped=0, timeout=0; spi_transmit=0, spi_data=0, spi_dc=0; client_busy=all 1s.
// - FSM IDLE -> GRANT -> DRAIN -> IDLE.
// - IDLE: if |req, winner = first set req scanning last+1, last+2, ... modulo NUM_CLIENTS;
//   next cycle grant=onehot(winner), owner=winner, last=winner, active=1, go GRANT.
//   No req: stay IDLE. Latency req->grant = 1 cycle from a clean IDLE.
// - GRANT: spi_data/spi_dc/spi_transmit = owner's signals combinationally;
//   spi_transmit = client_transmit[owner] & grant[owner] only. Hold counter increments.
//   req[owner] falls -> DRAIN. MAX_HOLD!=0 and counter reaches MAX_HOLD-1 -> DRAIN,
//   timeout pulses 1 cycle.
// - DRAIN: transmit of owner still forwarded (strobe in the cycle req falls is honoured);
//   stay until spi_busy=0 and client_transmit[owner]=0, then grant=0, active=0, IDLE.
// - Minimum one IDLE cycle between grants; a still-requesting owner re-competes in
//   round-robin, so it regains the bus only if no other client is requesting.
// - spi_data/spi_dc = 0 and spi_transmit = 0 whenever active=0.
// - client_transmit from a non-owner (or any client while active=0) is never forwarded;
//   it raises dropped for 1 cycle (registered, 1 cycle later).
// - Simultaneous req in IDLE: round-robin order above decides; ties impossible.
// - Owner drops req while spi_busy=1: grant held through DRAIN until spi_busy=0.
// - Timeout revocation is not preemptive mid-byte: DRAIN still waits for spi_busy=0.
// - rst mid-burst: all outputs return to reset values next cycle; in-flight SPI byte
//   is tft_spi's concern (it shares rst).
// - Hold counter saturates at 2^20-1; cleared on entry to GRANT.
// TESTING
// 1 Reset, req=0001, client0 strobes 3 bytes 0x2A/0x2B/0x2C, dc=0 -> grant=0001 one
//   cycle after req, spi_data/spi_transmit reproduce 3 strobes in order, no dropped.
// 2 req=1111 simultaneously after reset (last=3) -> grants in order 0,1,2,3, each
//   separated by >=1 cycle with active=0; spi_transmit never 1 while active=0.
// 3 Owner drops req while spi_busy=1 for 16 cycles -> grant held 16 cycles in DRAIN,
//   release on first spi_busy=0 cycle; pending req=0100 granted 1 cycle after.
// 4 Client1 strobes transmit while client0 owns -> spi_transmit stays 0, dropped
//   pulses once, client_busy[1]=1 throughout.
// 5 MAX_HOLD=8, client2 holds req forever, client0 requesting -> timeout pulses after
//   8 grant cycles, next grant goes to client0.
// 6 Assert rst mid-burst with spi_busy=1 -> next cycle grant=0, active=0, IDLE; re-req
//   after release is granted normally.

Source files
------------

// File: rtl/tft_bus_arbiter.sv
// rtl/tft_bus_arbiter.sv - round-robin burst arbiter sharing one tft_spi byte transmitter
module tft_bus_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int MAX_HOLD    = 0,
  localparam int OWNER_W    = $clog2(NUM_CLIENTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CLIENTS-1:0]   req,
  input  logic [8*NUM_CLIENTS-1:0] client_data,
  input  logic [NUM_CLIENTS-1:0]   client_dc,
  input  logic [NUM_CLIENTS-1:0]   client_transmit,
  output logic [NUM_CLIENTS-1:0]   client_busy,
  output logic [NUM_CLIENTS-1:0]   grant,
  output logic [OWNER_W-1:0]       owner,
  output logic                     active,
  input  logic                     spi_busy,
  output logic [7:0]               spi_data,
  output logic                     spi_dc,
  output logic                     spi_transmit,
  output logic                     dropped,
  output logic                     timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]         state;
  logic [OWNER_W-1:0] last;
  logic [OWNER_W-1:0] winner;
  logic [OWNER_W-1:0] idx_w;
  logic [19:0]        hold_cnt;
  logic [7:0]         data_arr [NUM_CLIENTS];
  logic               owner_req;
  logic               owner_tx;
  logic               timeout_hit;
  int                 idx;

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign data_arr[g] = client_data[8*g +: 8];
  end

  // Scan last+1, last+2, ... ; iterating backwards lets the nearest requester win.
  always_comb begin
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      idx_w = OWNER_W'(idx);
      if (req[idx_w]) winner = idx_w;
    end
  end

  assign owner_req   = req[owner];
  assign owner_tx    = client_transmit[owner];
  assign timeout_hit = (MAX_HOLD != 0) && (hold_cnt == 20'(MAX_HOLD - 1));

  always_comb begin
    spi_transmit = active & owner_tx & grant[owner];
    spi_data     = active ? data_arr[owner] : 8'h00;
    spi_dc       = active & client_dc[owner];
    client_busy  = (grant & {NUM_CLIENTS{spi_busy}}) | ~grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      active   <= 1'b0;
      last     <= OWNER_W'(NUM_CLIENTS - 1);
      hold_cnt <= '0;
      dropped  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      // grant is all-zero while idle, so any strobe then counts as dropped too
      dropped <= |(client_transmit & ~grant);
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant    <= {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << winner;
            owner    <= winner;
            last     <= winner;
            active   <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + 20'd1;
          if (!owner_req) begin
            state <= DRAIN;
          end else if (timeout_hit) begin
            state   <= DRAIN;
            timeout <= 1'b1;
          end
        end
        DRAIN: begin
          // A byte still shifting or being strobed keeps the bus with its owner.
          if (!spi_busy && !owner_tx) begin
            grant  <= '0;
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
